aes_key_schedule_gen: RTL

Parametrised AES key-schedule generator for the AES datapath. It accepts a 128-, 192- or 256-bit cipher key, expands it iteratively at one 32-bit word per cycle into an internal round-key buffer, and then serves any round key by index in encrypt order or decrypt (reversed) order. It replaces the per-round, AES-128-only key expanders: the encrypt and decrypt round engines both read round keys from this block.

---
 rtl/aes_key_schedule_gen.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/aes_key_schedule_gen.sv
// AES key-schedule generator: expands a 128/192/256-bit cipher key one word per
// cycle into a round-key buffer, then serves round keys in encrypt or decrypt order.
module aes_key_schedule_gen #(
    parameter int MAX_NK = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [255:0] key_in,
    input  logic [1:0]   key_len,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         key_err,
    output logic         busy,
    output logic         key_done,
    output logic [3:0]   num_rounds,
    input  logic         rk_rd_en,
    input  logic [3:0]   rk_idx,
    input  logic         rk_dec,
    output logic [127:0] rk_out,
    output logic         rk_out_valid
);
    localparam int         DEPTH    = 4 * (MAX_NK + 7);
    localparam int         IW       = $clog2(DEPTH);
    localparam logic [3:0] MAX_NK_W = 4'(MAX_NK);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            else      p = p;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254, zero maps to zero) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    state_t        state_q;
    logic [31:0]   w_q [DEPTH];
    logic [IW-1:0] i_q;
    logic [3:0]    j_q;
    logic [3:0]    nk_q;
    logic [3:0]    nr_q;
    logic [7:0]    rcon_q;
    logic          key_ready_q;
    logic          key_err_q;
    logic          busy_q;
    logic          key_done_q;
    logic [127:0]  rk_out_q;
    logic          rk_valid_q;

    logic [3:0]    nk_s;
    logic [3:0]    nr_s;
    logic          legal_s;
    logic [31:0]   prev_s;
    logic [31:0]   old_s;
    logic [31:0]   temp_s;
    logic [31:0]   new_word_s;
    logic [IW-1:0] last_s;
    logic [3:0]    eff_s;
    logic [IW-1:0] base_s;

    // Decode the offered key length and check it against the configured maximum
    always_comb begin
        nk_s    = 4'd0;
        nr_s    = 4'd0;
        legal_s = 1'b0;
        case (key_len)
            2'b00:   begin nk_s = 4'd4; nr_s = 4'd10; end
            2'b01:   begin nk_s = 4'd6; nr_s = 4'd12; end
            2'b10:   begin nk_s = 4'd8; nr_s = 4'd14; end
            default: begin nk_s = 4'd0; nr_s = 4'd0;  end
        endcase
        if ((nk_s != 4'd0) && (nk_s <= MAX_NK_W)) legal_s = 1'b1;
        else                                      legal_s = 1'b0;
    end

    // Next schedule word; j_q tracks i mod Nk so no divider is needed
    always_comb begin
        prev_s = w_q[i_q - IW'(1)];
        old_s  = w_q[i_q - IW'(nk_q)];
        if (j_q == 4'd0) begin
            temp_s = sub_word({prev_s[23:0], prev_s[31:24]}) ^ {rcon_q, 24'h000000};
        end else if ((nk_q == 4'd8) && (j_q == 4'd4)) begin
            temp_s = sub_word(prev_s);
        end else begin
            temp_s = prev_s;
        end
        new_word_s = old_s ^ temp_s;
        last_s     = IW'({nr_q, 2'b11});
    end

    // Round-key read address: decrypt order counts down from Nr
    always_comb begin
        if (rk_dec) eff_s = nr_q - rk_idx;
        else        eff_s = rk_idx;
        base_s = IW'({eff_s, 2'b00});
    end

    // Control FSM, word buffer and registered read port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            i_q         <= '0;
            j_q         <= 4'd0;
            nk_q        <= 4'd0;
            nr_q        <= 4'd0;
            rcon_q      <= 8'h00;
            key_ready_q <= 1'b1;
            key_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            key_done_q  <= 1'b0;
            rk_out_q    <= 128'h0;
            rk_valid_q  <= 1'b0;
            for (int k = 0; k < DEPTH; k++) w_q[k] <= 32'h0;
        end else begin
            key_err_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (key_valid) begin
                        if (legal_s) begin
                            for (int k = 0; k < MAX_NK; k++) w_q[k] <= key_in[255 - 32*k -: 32];
                            i_q         <= IW'(nk_s);
                            j_q         <= 4'd0;
                            nk_q        <= nk_s;
                            nr_q        <= nr_s;
                            rcon_q      <= 8'h01;
                            key_done_q  <= 1'b0;
                            busy_q      <= 1'b1;
                            key_ready_q <= 1'b0;
                            state_q     <= ST_EXPAND;
                        end else begin
                            key_err_q <= 1'b1;
                        end
                    end else begin
                        state_q <= state_q;
                    end
                end
                ST_EXPAND: begin
                    w_q[i_q] <= new_word_s;
                    i_q      <= i_q + IW'(1);
                    if (j_q == nk_q - 4'd1) j_q <= 4'd0;
                    else                    j_q <= j_q + 4'd1;
                    if (j_q == 4'd0) rcon_q <= xtime(rcon_q);
                    else             rcon_q <= rcon_q;
                    if (i_q == last_s) begin
                        key_done_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        key_ready_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        state_q <= ST_EXPAND;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    key_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase

            if (rk_rd_en && key_done_q) begin
                rk_valid_q <= 1'b1;
                if (rk_idx > nr_q) begin
                    rk_out_q <= 128'h0;
                end else begin
                    rk_out_q <= {w_q[base_s], w_q[base_s + IW'(1)],
                                 w_q[base_s + IW'(2)], w_q[base_s + IW'(3)]};
                end
            end else begin
                rk_valid_q <= 1'b0;
            end
        end
    end

    assign key_ready    = key_ready_q;
    assign key_err      = key_err_q;
    assign busy         = busy_q;
    assign key_done     = key_done_q;
    assign num_rounds   = nr_q;
    assign rk_out       = rk_out_q;
    assign rk_out_valid = rk_valid_q;

endmodule
